// File: rtl/xalu_pkg.sv
// xalu_pkg: shared definitions for the XALU multiply/divide unit.
//   - 3-bit opcode encodings XALU_MULT .. XALU_MSUB
//   - is_long_op(): 1 for ops that run through the multi-cycle busy window
//     (MULT, MULTU, DIV, DIVU, MADD, MSUB); 0 for MTHI/MTLO.
package xalu_pkg;

  localparam logic [2:0] XALU_MULT  = 3'd0;
  localparam logic [2:0] XALU_MULTU = 3'd1;
  localparam logic [2:0] XALU_DIV   = 3'd2;
  localparam logic [2:0] XALU_DIVU  = 3'd3;
  localparam logic [2:0] XALU_MTHI  = 3'd4;
  localparam logic [2:0] XALU_MTLO  = 3'd5;
  localparam logic [2:0] XALU_MADD  = 3'd6;
  localparam logic [2:0] XALU_MSUB  = 3'd7;

  function automatic logic is_long_op(input logic [2:0] op);
    return !(op == XALU_MTHI || op == XALU_MTLO);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == XALU_DIV || op == XALU_DIVU);
  endfunction

endpackage

// File: rtl/xalu_calc.sv
// xalu_calc: purely combinational result generator for the XALU long ops.
// Ports:
//   op     in  3       opcode (xalu_pkg encodings)
//   a, b   in  WIDTH   rs / rt operands
//   hi, lo in  WIDTH   current HI/LO (accumulator for MADD/MSUB)
//   res    out 2*WIDTH {hi_n, lo_n} result; MTHI/MTLO yield {hi, lo} unchanged
module xalu_calc
  import xalu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] sa_x, sb_x, sprod;
  logic        [2*WIDTH-1:0] ua_x, ub_x, uprod, acc;
  logic signed [WIDTH-1:0]   sa, sb, squot, srem;
  logic        [WIDTH-1:0]   uquot, urem;
  logic                      div_zero, div_ovf;

  always_comb begin
    sa_x  = {{WIDTH{a[WIDTH-1]}}, a};
    sb_x  = {{WIDTH{b[WIDTH-1]}}, b};
    ua_x  = {{WIDTH{1'b0}}, a};
    ub_x  = {{WIDTH{1'b0}}, b};
    // 2W x 2W truncated to 2W is the exact product for W-bit operands
    sprod = sa_x * sb_x;
    uprod = ua_x * ub_x;
    acc   = {hi, lo};

    sa    = a;
    sb    = b;
    squot = sa / sb;
    srem  = sa % sb;
    uquot = a / b;
    urem  = a % b;

    div_zero = (b == '0);
    div_ovf  = (a == MIN_INT) && (b == {WIDTH{1'b1}});

    res = acc;
    case (op)
      XALU_MULT:  res = sprod;
      XALU_MULTU: res = uprod;
      XALU_MADD:  res = acc + sprod;
      XALU_MSUB:  res = acc - sprod;
      XALU_DIV: begin
        if (div_zero)     res = {a, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, MIN_INT};
        else              res = {srem, squot};
      end
      XALU_DIVU: begin
        if (div_zero) res = {a, {WIDTH{1'b1}}};
        else          res = {urem, uquot};
      end
      default:    res = acc;
    endcase
  end

endmodule

// File: rtl/xalu_md_unit.sv
// xalu_md_unit: multi-cycle multiply/divide unit owning HI/LO.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-low reset
//   start  in   1      XALU op present in E stage
//   op     in   3      opcode (xalu_pkg)
//   a, b   in   WIDTH  rs / rt operands
//   flush  in   1      abort in-flight op, drop same-cycle start
//   busy   out  1      registered; high while a long op is in flight
//   hi, lo out  WIDTH  HI / LO registers
// The full result is computed at acceptance and parked in a pending register;
// the counter only models latency, committing the pending value at the end.
module xalu_md_unit
  import xalu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   count_load;
  logic [2*WIDTH-1:0] pending;
  logic [2*WIDTH-1:0] calc_res;

  xalu_calc #(.WIDTH(WIDTH)) u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi),
    .lo  (lo),
    .res (calc_res)
  );

  always_comb begin
    count_load = is_div_op(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      counter <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      // flush beats both completion and any same-cycle start
      busy    <= 1'b0;
      counter <= '0;
      pending <= '0;
    end else if (busy) begin
      // starts while busy are ignored; only the countdown advances
      if (counter == '0) begin
        {hi, lo} <= pending;
        busy     <= 1'b0;
      end else begin
        counter <= counter - 1'b1;
      end
    end else if (start) begin
      if (is_long_op(op)) begin
        pending <= calc_res;
        counter <= count_load;
        busy    <= 1'b1;
      end else if (op == XALU_MTHI) begin
        hi <= a;
      end else begin
        lo <= a;
      end
    end
  end

endmodule
